iomem_arbiter: RTL and testbench

//  Shares the SoC iomem peripheral bus between two masters (m0: CPU iomem port, m1: debug/DMA

---
 rtl/iomem_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_iomem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_arbiter.sv
// -----------------------------------------------------------------------------
// iomem_arbiter
//
// Shares the SoC iomem peripheral bus between two masters (m0 = CPU iomem
// port, m1 = debug/DMA master) and decodes the granted request onto NSLV
// 64 KiB peripheral windows starting at SLV_BASE (addr[31:16]). Only one
// transfer is outstanding at a time. The winning request is latched into
// registers, so master inputs may change freely once a transfer is accepted.
//
// Optional feature (macro IOMEM_ARB_TIMEOUT_EN):
//   When defined, a slave that holds off s_ready for TIMEOUT BUSY cycles is
//   abandoned. The master then gets rdata 32'hFFFF_FFFF and bus_err pulses.
//   When undefined, BUSY waits indefinitely and TIMEOUT is only range-checked.
//
// Ports
//   clk                  system clock
//   rst                  asynchronous reset, active low
//   m0_/m1_valid         master request, held until the matching ready
//   m0_/m1_ready         one-cycle transfer-complete pulse
//   m0_/m1_addr          byte address
//   m0_/m1_wdata         write data
//   m0_/m1_wstrb         byte strobes (4'h0 = read)
//   m0_/m1_rdata         read data, valid while ready=1, zero otherwise
//   s_valid[NSLV]        one-hot slave request
//   s_ready[NSLV]        per-slave completion
//   s_rdata[32*NSLV]     slave i read data at [32*i +: 32]
//   s_addr/wdata/wstrb   registered copy of the granted request
//   bus_err              one-cycle pulse on unmapped access or timeout
// -----------------------------------------------------------------------------
module iomem_arbiter #(
  parameter int unsigned NSLV     = 2,
  parameter logic [15:0] SLV_BASE = 16'h0300,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_valid,
  output logic               m0_ready,
  input  logic [31:0]        m0_addr,
  input  logic [31:0]        m0_wdata,
  input  logic [3:0]         m0_wstrb,
  output logic [31:0]        m0_rdata,
  input  logic               m1_valid,
  output logic               m1_ready,
  input  logic [31:0]        m1_addr,
  input  logic [31:0]        m1_wdata,
  input  logic [3:0]         m1_wstrb,
  output logic [31:0]        m1_rdata,
  output logic [NSLV-1:0]    s_valid,
  input  logic [NSLV-1:0]    s_ready,
  input  logic [32*NSLV-1:0] s_rdata,
  output logic [31:0]        s_addr,
  output logic [31:0]        s_wdata,
  output logic [3:0]         s_wstrb,
  output logic               bus_err
);

  if (NSLV < 1 || NSLV > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("iomem_arbiter: NSLV must be 1..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // id of the master served last
  logic              gnt_q, gnt_d;                // id of the master being served
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [NSLV-1:0]   s_valid_q, s_valid_d;

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  // Request selection and address decode of the candidate request.
  logic              any_req;
  logic              sel;
  logic [31:0]       req_addr;
  logic [15:0]       slv_off;
  logic              mapped;
  logic              slv_hit;
  logic [31:0]       slv_rdata;

  always_comb begin
    any_req = m0_valid | m1_valid;
    // Tie goes to the master that was not served last; a lone requester wins.
    if (m0_valid && m1_valid) begin
      sel = ~last_grant_q;
    end else begin
      sel = m1_valid;
    end
    req_addr = sel ? m1_addr : m0_addr;
    // Unsigned 16-bit difference: addresses below SLV_BASE wrap to large
    // values and therefore fall outside the window range as well.
    slv_off  = req_addr[31:16] - SLV_BASE;
    mapped   = (slv_off < 16'(NSLV));
  end

  // s_valid_q is one-hot while BUSY, so masking avoids indexing by a number
  // and makes ready from unselected slaves irrelevant.
  always_comb begin
    slv_hit   = |(s_ready & s_valid_q);
    slv_rdata = 32'h0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (s_valid_q[i]) begin
        slv_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    s_valid_d    = s_valid_q;
`ifdef IOMEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d        = sel;
          last_grant_d = sel;
          addr_d       = req_addr;
          wdata_d      = sel ? m1_wdata : m0_wdata;
          wstrb_d      = sel ? m1_wstrb : m0_wstrb;
          if (mapped) begin
            state_d = BUSY;
            err_d   = 1'b0;
            for (int i = 0; i < int'(NSLV); i++) begin
              s_valid_d[i] = (slv_off == 16'(i));
            end
`ifdef IOMEM_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
          end else begin
            // Unmapped: answer directly, no slave is ever selected.
            state_d = RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end
        end
      end

      BUSY: begin
        if (slv_hit) begin
          // Completion on the expiry cycle still counts as a normal finish.
          state_d   = RESP;
          rdata_d   = slv_rdata;
          err_d     = 1'b0;
          s_valid_d = '0;
        end
`ifdef IOMEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = RESP;
          rdata_d   = 32'hFFFF_FFFF;
          err_d     = 1'b1;
          s_valid_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        s_valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      s_valid_q    <= '0;
`ifdef IOMEM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      s_valid_q    <= s_valid_d;
`ifdef IOMEM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Response signalling is decoded from the state so that an asynchronous
  // reset clears it in the same instant as the state register.
  always_comb begin
    m0_ready = (state_q == RESP) && !gnt_q;
    m1_ready = (state_q == RESP) &&  gnt_q;
    m0_rdata = m0_ready ? rdata_q : 32'h0;
    m1_rdata = m1_ready ? rdata_q : 32'h0;
    bus_err  = (state_q == RESP) && err_q;
  end

  assign s_valid = s_valid_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_wstrb = wstrb_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
module tb_iomem_arbiter;

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  s_valid, s_ready, rdy_mask;
  logic [63:0] s_rdata;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        bus_err;

  int tests = 0;
  int fails = 0;

  // Slave model: slave 0 returns A5, slave 1 returns 1111_0001; rdy_mask
  // selects which slaves answer in the same cycle they are selected.
  assign s_rdata = {32'h1111_0001, 32'h0000_00A5};
  assign s_ready = s_valid & rdy_mask;

  always #5 clk = ~clk;

  iomem_arbiter #(.NSLV(2), .SLV_BASE(16'h0300), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .bus_err(bus_err)
  );

  task automatic do_reset();
    rst = 1'b0;
    m0_valid = 0; m1_valid = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    m0_wstrb = 0; m1_wstrb = 0;
    rdy_mask = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [136:0] all_out;
    rst = 1'b0;
    m0_valid = 0; m1_valid = 0; rdy_mask = 2'b11;
    @(negedge clk);
    all_out = {m0_ready, m1_ready, s_valid, bus_err, s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata};
    tests++;
    if (all_out !== 137'b0) begin
      $display("FAIL reset_outputs: got %h expected 0", all_out); fails++;
    end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_addr = 32'h0300_0000; m0_wstrb = 4'h0; m0_valid = 1;
    @(negedge clk);  // cycle 1: IDLE
    tests++;
    if (s_valid !== 2'b00 || m0_ready !== 1'b0) begin
      $display("FAIL t1_cycle1: s_valid=%b m0_ready=%b expected 00/0", s_valid, m0_ready); fails++;
    end
    @(negedge clk);  // cycle 2: BUSY
    tests++;
    if (s_valid !== 2'b01 || s_addr !== 32'h0300_0000 || m0_ready !== 1'b0) begin
      $display("FAIL t1_busy: s_valid=%b s_addr=%h m0_ready=%b expected 01/03000000/0", s_valid, s_addr, m0_ready); fails++;
    end
    m0_addr = 32'h0301_0000;  // must not disturb the latched copy
    @(negedge clk);  // cycle 3: RESP
    tests++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h0000_00A5 || bus_err !== 1'b0 || s_valid !== 2'b00 || m1_ready !== 1'b0) begin
      $display("FAIL t1_resp: rdy=%b rdata=%h err=%b s_valid=%b m1_rdy=%b expected 1/000000A5/0/00/0",
               m0_ready, m0_rdata, bus_err, s_valid, m1_ready); fails++;
    end
    tests++;
    if (s_addr !== 32'h0300_0000) begin
      $display("FAIL t1_addr_stable: got %h expected 03000000", s_addr); fails++;
    end
    @(posedge clk); #1 m0_valid = 0;
    @(negedge clk);
    tests++;
    if (m0_ready !== 1'b0 || m0_rdata !== 32'h0) begin
      $display("FAIL t1_after: rdy=%b rdata=%h expected 0/0", m0_ready, m0_rdata); fails++;
    end
  endtask

  task automatic test_contention();
    do_reset();
    m0_addr = 32'h0300_0004; m0_wdata = 32'hDEAD_BEEF; m0_wstrb = 4'hF; m0_valid = 1;
    m1_addr = 32'h0301_0000; m1_wstrb = 4'h0; m1_valid = 1;
    @(negedge clk);
    @(negedge clk);  // BUSY for m0
    tests++;
    if (s_valid !== 2'b01 || s_wstrb !== 4'hF || s_addr !== 32'h0300_0004 || s_wdata !== 32'hDEAD_BEEF) begin
      $display("FAIL t2_m0_busy: s_valid=%b wstrb=%h addr=%h wdata=%h expected 01/F/03000004/DEADBEEF",
               s_valid, s_wstrb, s_addr, s_wdata); fails++;
    end
    @(negedge clk);  // RESP for m0
    tests++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      $display("FAIL t2_m0_resp: m0_rdy=%b m1_rdy=%b expected 1/0", m0_ready, m1_ready); fails++;
    end
    @(posedge clk); #1 m0_valid = 0;
    @(negedge clk);  // IDLE
    @(negedge clk);  // BUSY for m1
    tests++;
    if (s_valid !== 2'b10 || s_wstrb !== 4'h0 || s_addr !== 32'h0301_0000) begin
      $display("FAIL t2_m1_busy: s_valid=%b wstrb=%h addr=%h expected 10/0/03010000", s_valid, s_wstrb, s_addr); fails++;
    end
    @(negedge clk);  // RESP for m1
    tests++;
    if (m1_ready !== 1'b1 || m1_rdata !== 32'h1111_0001 || m0_ready !== 1'b0) begin
      $display("FAIL t2_m1_resp: m1_rdy=%b rdata=%h m0_rdy=%b expected 1/11110001/0", m1_ready, m1_rdata, m0_ready); fails++;
    end
    @(posedge clk); #1 m1_valid = 0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [5:0] who = '0;
    bit both = 0;
    bit bad_data = 0;
    do_reset();
    m0_addr = 32'h0300_0000; m0_valid = 1;
    m1_addr = 32'h0301_0000; m1_valid = 1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      if (m0_ready && m1_ready) begin
        both = 1;
      end else if (m0_ready) begin
        who[n] = 1'b0;
        if (m0_rdata !== 32'h0000_00A5) bad_data = 1;
        n++;
      end else if (m1_ready) begin
        who[n] = 1'b1;
        if (m1_rdata !== 32'h1111_0001) bad_data = 1;
        n++;
      end
    end
    @(posedge clk); #1 m0_valid = 0; m1_valid = 0;
    tests++;
    if (n !== 6) begin
      $display("FAIL t3_count: got %0d transfers expected 6", n); fails++;
    end
    tests++;
    if (who !== 6'b101010 || both) begin
      $display("FAIL t3_order: grant bits=%b both=%0d expected 101010/0", who, both); fails++;
    end
    tests++;
    if (bad_data) begin
      $display("FAIL t3_rdata: bad_data=%0d expected 0", bad_data); fails++;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [3] = '{32'h0400_0000, 32'h0302_0000, 32'h02FF_FFFC};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      m1_addr = addrs[k]; m1_valid = 1;
      @(negedge clk);  // cycle 1
      tests++;
      if (m1_ready !== 1'b0 || bus_err !== 1'b0) begin
        $display("FAIL t4_cycle1[%0d]: rdy=%b err=%b expected 0/0", k, m1_ready, bus_err); fails++;
      end
      @(negedge clk);  // cycle 2: RESP
      tests++;
      if (m1_ready !== 1'b1 || m1_rdata !== 32'h0 || bus_err !== 1'b1 || s_valid !== 2'b00 || m0_ready !== 1'b0) begin
        $display("FAIL t4_resp[%0d]: rdy=%b rdata=%h err=%b s_valid=%b m0_rdy=%b expected 1/0/1/00/0",
                 k, m1_ready, m1_rdata, bus_err, s_valid, m0_ready); fails++;
      end
      @(posedge clk); #1 m1_valid = 0;
      @(negedge clk);
      tests++;
      if (bus_err !== 1'b0 || m1_ready !== 1'b0 || s_valid !== 2'b00) begin
        $display("FAIL t4_after[%0d]: err=%b rdy=%b s_valid=%b expected 0/0/00", k, bus_err, m1_ready, s_valid); fails++;
      end
    end
  endtask

  task automatic test_timeout();
    bit held = 1;
    do_reset();
    rdy_mask = 2'b00;
    m0_addr = 32'h0300_0000; m0_valid = 1;
    @(negedge clk);  // cycle 1: IDLE
`ifdef IOMEM_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (s_valid !== 2'b01 || m0_ready !== 1'b0 || bus_err !== 1'b0) held = 0;
    end
    tests++;
    if (!held) begin
      $display("FAIL t5_wait: held=%0d expected 1", held); fails++;
    end
    @(negedge clk);
    tests++;
    if (s_valid !== 2'b00 || m0_ready !== 1'b1 || m0_rdata !== 32'hFFFF_FFFF || bus_err !== 1'b1) begin
      $display("FAIL t5_expire: s_valid=%b rdy=%b rdata=%h err=%b expected 00/1/FFFFFFFF/1",
               s_valid, m0_ready, m0_rdata, bus_err); fails++;
    end
    @(posedge clk); #1 m0_valid = 0;
    // Completion on the very cycle the counter expires.
    do_reset();
    rdy_mask = 2'b00;
    m0_addr = 32'h0300_0000; m0_valid = 1;
    @(negedge clk);
    repeat (7) @(negedge clk);
    @(negedge clk);  // eighth BUSY cycle
    rdy_mask = 2'b01;
    @(negedge clk);
    tests++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h0000_00A5 || bus_err !== 1'b0) begin
      $display("FAIL t5_race: rdy=%b rdata=%h err=%b expected 1/000000A5/0", m0_ready, m0_rdata, bus_err); fails++;
    end
    @(posedge clk); #1 m0_valid = 0;
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_valid !== 2'b01 || m0_ready !== 1'b0 || bus_err !== 1'b0) held = 0;
    end
    tests++;
    if (!held) begin
      $display("FAIL t5_wait_forever: held=%0d expected 1", held); fails++;
    end
    rdy_mask = 2'b01;
    @(negedge clk);
    tests++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h0000_00A5 || bus_err !== 1'b0) begin
      $display("FAIL t5_late_ready: rdy=%b rdata=%h err=%b expected 1/000000A5/0", m0_ready, m0_rdata, bus_err); fails++;
    end
    @(posedge clk); #1 m0_valid = 0;
`endif
    rdy_mask = 2'b11;
  endtask

  task automatic test_reset_mid();
    logic [136:0] all_out;
    do_reset();
    rdy_mask = 2'b00;
    m1_addr = 32'h0301_0000; m1_valid = 1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (s_valid !== 2'b10) begin
      $display("FAIL t6_busy: s_valid=%b expected 10", s_valid); fails++;
    end
    #1 rst = 1'b0;
    #1;
    all_out = {m0_ready, m1_ready, s_valid, bus_err, s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata};
    tests++;
    if (all_out !== 137'b0) begin
      $display("FAIL t6_async_clear: got %h expected 0", all_out); fails++;
    end
    m1_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    rdy_mask = 2'b11;
    @(posedge clk); #1;
    m0_addr = 32'h0300_0000; m0_valid = 1;
    m1_addr = 32'h0301_0000; m1_valid = 1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (s_valid !== 2'b01) begin
      $display("FAIL t6_m0_priority: s_valid=%b expected 01", s_valid); fails++;
    end
    @(negedge clk);
    tests++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_rdata !== 32'h0000_00A5) begin
      $display("FAIL t6_m0_resp: m0_rdy=%b m1_rdy=%b rdata=%h expected 1/0/000000A5", m0_ready, m1_ready, m0_rdata); fails++;
    end
    @(posedge clk); #1 m0_valid = 0; m1_valid = 0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
